// File: rtl/fetch_unit_if.sv
// Decode-side handshake of the fetch unit: buffer head word, its PC and valid/ready.
interface fetch_unit_if #(
   parameter int AW = 5,
   parameter int IW = 36
);
   logic          id_valid;
   logic          id_ready;
   logic [IW-1:0] id_inst;
   logic [AW-1:0] id_pc;

   modport master (output id_valid, output id_inst, output id_pc, input id_ready);
   modport slave  (input id_valid, input id_inst, input id_pc, output id_ready);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch controller: program load path, PC sequencing over a synchronous
// program memory, 2-entry decode buffer with redirect and HALT handling.
//
// state   | meaning
// S_IDLE  | waiting for load_en or start; memory strobes idle
// S_LOAD  | single write cycle, load word driven onto pm_inst
// S_FETCH | memory read every cycle, words accepted per buffer credit
// S_HALT  | HALT word captured, no new issues, buffer drains
module fetch_unit #(
   parameter int AW = 5,
   parameter int IW = 36
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [IW-1:0] load_data,
   input  logic          start,
   input  logic [AW-1:0] start_pc,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_pc,
   output logic [AW-1:0] pm_address,
   output logic          pm_rd,
   output logic          pm_wr,
   output logic [IW-1:0] pm_wdata,
   inout  wire  [IW-1:0] pm_inst,
   fetch_unit_if.master  dec,
   output logic          halted
);
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FETCH, S_HALT} state_t;
   localparam logic [2:0] OP_HALT = 3'b111;

   state_t        state, state_next;
   logic [AW-1:0] pc, inflight_pc;
   logic          inflight;
   logic [IW-1:0] buf_inst [2];
   logic [AW-1:0] buf_pc [2];
   logic [1:0]    occ;
   logic          head, tail;
   logic          load_go, start_go, flush, issue, capture, pop, halt_hit;
   logic [2:0]    credit;

   assign tail         = head ^ occ[0];
   assign pm_inst      = (state == S_LOAD) ? pm_wdata : {IW{1'bz}};
   assign dec.id_valid = (occ != 2'd0);
   assign dec.id_inst  = buf_inst[head];
   assign dec.id_pc    = buf_pc[head];

   // pm_address always shows the PC, so the memory reads speculatively every
   // FETCH cycle; an issue only decides whether the word on the bus next cycle is kept.
   always_comb begin
      state_next = state;
      load_go    = 1'b0;
      start_go   = 1'b0;
      flush      = 1'b0;
      issue      = 1'b0;
      capture    = 1'b0;
      halt_hit   = 1'b0;
      pop        = 1'b0;
      credit     = 3'd0;
      unique case (state)
         S_IDLE: begin
            if (load_en) begin
               load_go    = 1'b1;
               state_next = S_LOAD;
            end else if (start) begin
               start_go   = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_LOAD: state_next = S_IDLE;
         S_FETCH, S_HALT: begin
            if (redirect) begin
               flush      = 1'b1;
               state_next = S_FETCH;
            end else begin
               pop      = dec.id_valid & dec.id_ready;
               capture  = inflight;
               halt_hit = inflight && (pm_inst[IW-1:IW-3] == OP_HALT);
               credit   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
               if (halt_hit) state_next = S_HALT;
               else if (state == S_FETCH) issue = (credit < 3'd2);
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc          <= '0;
         pm_address  <= '0;
         pm_rd       <= 1'b0;
         pm_wr       <= 1'b0;
         pm_wdata    <= '0;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         occ         <= '0;
         head        <= 1'b0;
         halted      <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            buf_inst[i] <= '0;
            buf_pc[i]   <= '0;
         end
      end else begin
         state    <= state_next;
         pm_rd    <= (state_next == S_FETCH) || (state_next == S_HALT);
         pm_wr    <= (state_next == S_LOAD);
         inflight <= issue;
         if (issue) inflight_pc <= pc;

         if (load_go) begin
            pm_address <= load_addr;
            pm_wdata   <= load_data;
         end else if (start_go) begin
            pc         <= start_pc;
            pm_address <= start_pc;
         end else if (flush) begin
            pc         <= redirect_pc;
            pm_address <= redirect_pc;
         end else if (issue) begin
            pc         <= pc + AW'(1);
            pm_address <= pc + AW'(1);
         end

         if (flush) begin
            occ    <= '0;
            head   <= 1'b0;
            halted <= 1'b0;
         end else begin
            if (capture) begin
               buf_inst[tail] <= pm_inst;
               buf_pc[tail]   <= inflight_pc;
            end
            if (pop) head <= ~head;
            occ <= occ + {1'b0, capture} - {1'b0, pop};
            if (halt_hit) halted <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a behavioural program memory and sequence model.
module tb_fetch_unit;
   localparam int AW = 5;
   localparam int IW = 36;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_en = 1'b0, start = 1'b0, redirect = 1'b0;
   logic [AW-1:0] load_addr = '0, start_pc = '0, redirect_pc = '0;
   logic [IW-1:0] load_data = '0;
   logic [AW-1:0] pm_address;
   logic          pm_rd, pm_wr, halted;
   logic [IW-1:0] pm_wdata;
   wire  [IW-1:0] pm_inst;

   fetch_unit_if #(.AW(AW), .IW(IW)) dec ();

   fetch_unit #(.AW(AW), .IW(IW)) dut (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .start(start), .start_pc(start_pc), .redirect(redirect),
      .redirect_pc(redirect_pc), .pm_address(pm_address), .pm_rd(pm_rd), .pm_wr(pm_wr),
      .pm_wdata(pm_wdata), .pm_inst(pm_inst), .dec(dec), .halted(halted)
   );

   always #5 clk = ~clk;

   // synchronous program memory: latch on edge, word on the bus the following cycle
   logic [IW-1:0] mem [32];
   logic [IW-1:0] mem_q = '0;
   logic          mem_oe = 1'b0;
   always @(posedge clk) begin
      if (pm_wr) mem[pm_address] <= pm_inst;
      mem_oe <= pm_rd;
      if (pm_rd) mem_q <= mem[pm_address];
   end
   assign pm_inst = mem_oe ? mem_q : {IW{1'bz}};

   int checks = 0, failures = 0, cyc_now = 0;
   logic [AW-1:0] got_pc[$];
   logic [IW-1:0] got_inst[$];
   int            got_cyc[$];

   task automatic step();
      @(posedge clk);
      #1;
      cyc_now++;
   endtask

   function automatic logic [IW-1:0] rand_word();
      logic [2:0]  op;
      logic [32:0] rest;
      op   = 3'($urandom_range(0, 6));
      rest = {1'($urandom_range(0, 1)), $urandom};
      return {op, rest};
   endfunction

   function automatic bit bus_idle();
      return (pm_inst === {IW{1'bz}}) || (pm_inst === {IW{1'b0}});
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; load_en = 1'b0; start = 1'b0; redirect = 1'b0; dec.id_ready = 1'b0;
      step(); step();
      rst_n = 1'b1;
   endtask

   // mode 0: ready high, 1: ready low, 2: random ready
   task automatic collect(input int n_want, input int max_cyc, input int mode);
      int seen = 0;
      for (int c = 0; c < max_cyc && seen < n_want; c++) begin
         dec.id_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
         if (dec.id_valid && dec.id_ready) begin
            got_pc.push_back(dec.id_pc);
            got_inst.push_back(dec.id_inst);
            got_cyc.push_back(cyc_now);
            seen++;
         end
         step();
      end
      dec.id_ready = 1'b0;
   endtask

   task automatic start_at(input logic [AW-1:0] sp);
      start_pc = sp; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; dec.id_ready = 1'b0;
      step(); step();
      checks++;
      if (pm_address !== '0 || pm_rd !== 1'b0 || pm_wr !== 1'b0 || pm_wdata !== '0 ||
          dec.id_valid !== 1'b0 || dec.id_inst !== '0 || dec.id_pc !== '0 || halted !== 1'b0 || !bus_idle()) begin
         failures++;
         $display("FAIL reset_values addr=%h rd=%b wr=%b wdata=%h valid=%b inst=%h pc=%h halted=%b bus=%h (want all zero, bus z)",
                  pm_address, pm_rd, pm_wr, pm_wdata, dec.id_valid, dec.id_inst, dec.id_pc, halted, pm_inst);
      end
      rst_n = 1'b1;
      redirect = 1'b1; redirect_pc = 5'd5;
      step();
      redirect = 1'b0;
      step();
      checks++;
      if (pm_rd !== 1'b0 || dec.id_valid !== 1'b0) begin
         failures++;
         $display("FAIL redirect_in_idle rd=%b valid=%b (want 0 0)", pm_rd, dec.id_valid);
      end
   endtask

   task automatic test_load_latency();
      logic [IW-1:0] w [2];
      w[0] = 36'h0_0000_0001;
      w[1] = 36'h2_0000_0005;
      for (int i = 0; i < 2; i++) begin
         load_addr = AW'(i); load_data = w[i]; load_en = 1'b1; start = (i == 1);
         step();
         load_en = 1'b0; start = 1'b0;
         checks++;
         if (pm_wr !== 1'b1 || pm_rd !== 1'b0 || pm_address !== AW'(i) || pm_wdata !== w[i] || pm_inst !== w[i]) begin
            failures++;
            $display("FAIL load_cycle%0d wr=%b rd=%b addr=%h wdata=%h bus=%h (want 1 0 %h %h %h)",
                     i, pm_wr, pm_rd, pm_address, pm_wdata, pm_inst, i, w[i], w[i]);
         end
         step();
         checks++;
         if (pm_wr !== 1'b0 || pm_rd !== 1'b0 || mem[i] !== w[i]) begin
            failures++;
            $display("FAIL load_done%0d wr=%b rd=%b mem=%h (want 0 0 %h)", i, pm_wr, pm_rd, mem[i], w[i]);
         end
      end
      dec.id_ready = 1'b1;
      start_at('0);
      checks++;
      if (pm_address !== '0 || pm_rd !== 1'b1 || dec.id_valid !== 1'b0) begin
         failures++;
         $display("FAIL fetch_cycle1 addr=%h rd=%b valid=%b (want 0 1 0)", pm_address, pm_rd, dec.id_valid);
      end
      step();
      checks++;
      if (dec.id_valid !== 1'b0) begin
         failures++;
         $display("FAIL fetch_cycle2 valid=%b (want 0)", dec.id_valid);
      end
      for (int k = 0; k < 2; k++) begin
         step();
         checks++;
         if (dec.id_valid !== 1'b1 || dec.id_pc !== AW'(k) || dec.id_inst !== w[k]) begin
            failures++;
            $display("FAIL fetch_cycle%0d valid=%b pc=%h inst=%h (want 1 %h %h)", k + 3, dec.id_valid, dec.id_pc, dec.id_inst, k, w[k]);
         end
      end
      do_reset();
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 32; i++) mem[i] = IW'(i);
      got_pc.delete(); got_inst.delete(); got_cyc.delete();
      start_at(5'd30);
      collect(4, 20, 0);
      checks++;
      if (got_pc.size() != 4) begin
         failures++;
         $display("FAIL wrap_count got=%0d want=4", got_pc.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            logic [AW-1:0] ep;
            ep = AW'((30 + k) % 32);
            checks++;
            if (got_pc[k] !== ep || got_inst[k] !== IW'(ep) || got_cyc[k] != got_cyc[0] + k) begin
               failures++;
               $display("FAIL wrap_word%0d pc=%h inst=%h cyc=%0d (want %h %h %0d)",
                        k, got_pc[k], got_inst[k], got_cyc[k], ep, IW'(ep), got_cyc[0] + k);
            end
         end
      end
      do_reset();
   endtask

   task automatic test_backpressure();
      logic [AW-1:0] sp;
      int n_before, bad;
      for (int i = 0; i < 32; i++) mem[i] = rand_word();
      sp = AW'($urandom_range(0, 31));
      got_pc.delete(); got_inst.delete(); got_cyc.delete();
      start_at(sp);
      collect(4, 10, 0);
      n_before = got_pc.size();
      collect(99, 5, 1);
      checks++;
      if (dec.id_valid !== 1'b1 || got_pc.size() != n_before) begin
         failures++;
         $display("FAIL stall_hold valid=%b popped=%0d (want 1 %0d)", dec.id_valid, got_pc.size(), n_before);
      end
      collect(6, 10, 0);
      bad = 0;
      for (int k = n_before; k < got_cyc.size(); k++)
         if (got_cyc[k] != got_cyc[n_before] + (k - n_before)) bad++;
      checks++;
      if (bad != 0 || got_pc.size() != n_before + 6) begin
         failures++;
         $display("FAIL release_rate gaps=%0d words=%0d (want 0 %0d)", bad, got_pc.size(), n_before + 6);
      end
      collect(30, 300, 2);
      for (int k = 0; k < got_pc.size(); k++) begin
         logic [AW-1:0] ep;
         ep = AW'((int'(sp) + k) % 32);
         checks++;
         if (got_pc[k] !== ep || got_inst[k] !== mem[ep]) begin
            failures++;
            $display("FAIL bp_word%0d pc=%h inst=%h (want %h %h)", k, got_pc[k], got_inst[k], ep, mem[ep]);
         end
      end
      do_reset();
   endtask

   task automatic test_halt();
      for (int it = 0; it < 2; it++) begin
         logic [AW-1:0] sp, hp;
         int h;
         for (int i = 0; i < 32; i++) mem[i] = rand_word();
         sp = AW'($urandom_range(0, 31));
         h  = (it == 0) ? 3 : $urandom_range(0, 5);
         if (it == 0) sp = '0;
         hp = AW'((int'(sp) + h) % 32);
         mem[hp] = (it == 0) ? 36'hE_0000_0000 : {3'b111, 1'b0, $urandom};
         got_pc.delete(); got_inst.delete(); got_cyc.delete();
         start_at(sp);
         collect(99, 60, 2);
         collect(99, 4, 0);
         checks++;
         if (got_pc.size() != h + 1 || halted !== 1'b1 || dec.id_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt%0d_stop words=%0d halted=%b valid=%b (want %0d 1 0)", it, got_pc.size(), halted, dec.id_valid, h + 1);
         end
         for (int k = 0; k < got_pc.size() && k <= h; k++) begin
            logic [AW-1:0] ep;
            ep = AW'((int'(sp) + k) % 32);
            checks++;
            if (got_pc[k] !== ep || got_inst[k] !== mem[ep]) begin
               failures++;
               $display("FAIL halt%0d_word%0d pc=%h inst=%h (want %h %h)", it, k, got_pc[k], got_inst[k], ep, mem[ep]);
            end
         end
         redirect_pc = sp; redirect = 1'b1;
         step();
         redirect = 1'b0;
         checks++;
         if (halted !== 1'b0 || dec.id_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt%0d_redirect halted=%b valid=%b (want 0 0)", it, halted, dec.id_valid);
         end
         got_pc.delete(); got_inst.delete(); got_cyc.delete();
         collect(1, 10, 0);
         checks++;
         if (got_pc.size() != 1 || got_pc[0] !== sp || got_inst[0] !== mem[sp]) begin
            failures++;
            $display("FAIL halt%0d_restart words=%0d pc=%h (want 1 %h)", it, got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : '0, sp);
         end
         do_reset();
      end
   endtask

   task automatic test_redirect();
      logic [AW-1:0] rp;
      for (int i = 0; i < 32; i++) mem[i] = rand_word();
      start_at(AW'($urandom_range(0, 31)));
      collect(99, 6, 1);
      redirect_pc = 5'd10; redirect = 1'b1;
      step();
      redirect = 1'b0;
      checks++;
      if (dec.id_valid !== 1'b0) begin
         failures++;
         $display("FAIL redirect_full_flush valid=%b (want 0)", dec.id_valid);
      end
      got_pc.delete(); got_inst.delete(); got_cyc.delete();
      collect(6, 20, 0);
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (k >= got_pc.size() || got_pc[k] !== AW'(10 + k) || got_inst[k] !== mem[10 + k]) begin
            failures++;
            $display("FAIL redirect_full_word%0d got=%0d words (want pc %0d inst %h)", k, got_pc.size(), 10 + k, mem[10 + k]);
         end
      end
      dec.id_ready = 1'b1;
      step(); step();
      rp = AW'($urandom_range(0, 31));
      redirect_pc = rp; redirect = 1'b1;
      step();
      redirect = 1'b0;
      checks++;
      if (dec.id_valid !== 1'b0) begin
         failures++;
         $display("FAIL redirect_stream_n1 valid=%b (want 0)", dec.id_valid);
      end
      step();
      checks++;
      if (dec.id_valid !== 1'b0) begin
         failures++;
         $display("FAIL redirect_stream_n2 valid=%b (want 0)", dec.id_valid);
      end
      step();
      checks++;
      if (dec.id_valid !== 1'b1 || dec.id_pc !== rp || dec.id_inst !== mem[rp]) begin
         failures++;
         $display("FAIL redirect_stream_n3 valid=%b pc=%h inst=%h (want 1 %h %h)", dec.id_valid, dec.id_pc, dec.id_inst, rp, mem[rp]);
      end
      step();
      got_pc.delete(); got_inst.delete(); got_cyc.delete();
      collect(3, 10, 0);
      for (int k = 0; k < 3; k++) begin
         logic [AW-1:0] ep;
         ep = AW'((int'(rp) + 1 + k) % 32);
         checks++;
         if (k >= got_pc.size() || got_pc[k] !== ep) begin
            failures++;
            $display("FAIL redirect_stream_word%0d words=%0d (want pc %h)", k, got_pc.size(), ep);
         end
      end
      do_reset();
   endtask

   task automatic test_reset_mid();
      logic [IW-1:0] keep;
      keep = rand_word();
      mem[7] = keep;
      load_addr = 5'd7; load_data = ~keep; load_en = 1'b1; rst_n = 1'b0;
      step();
      load_en = 1'b0; rst_n = 1'b1;
      step();
      checks++;
      if (pm_wr !== 1'b0 || mem[7] !== keep || !bus_idle()) begin
         failures++;
         $display("FAIL reset_load_abort wr=%b mem=%h bus=%h (want 0 %h z)", pm_wr, mem[7], pm_inst, keep);
      end
      load_addr = 5'd9; load_data = rand_word(); load_en = 1'b1;
      step();
      load_en = 1'b0; rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++;
      if (pm_wr !== 1'b0 || pm_rd !== 1'b0 || pm_address !== '0 || pm_wdata !== '0 || !bus_idle()) begin
         failures++;
         $display("FAIL reset_in_load wr=%b rd=%b addr=%h wdata=%h bus=%h (want 0 0 0 0 z)", pm_wr, pm_rd, pm_address, pm_wdata, pm_inst);
      end
      for (int i = 0; i < 32; i++) mem[i] = rand_word();
      start_at(AW'($urandom_range(0, 31)));
      collect(99, 5, 2);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++;
      if (pm_rd !== 1'b0 || pm_wr !== 1'b0 || pm_address !== '0 || dec.id_valid !== 1'b0 ||
          dec.id_inst !== '0 || dec.id_pc !== '0 || halted !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_fetch rd=%b wr=%b addr=%h valid=%b inst=%h pc=%h halted=%b (want all 0)",
                  pm_rd, pm_wr, pm_address, dec.id_valid, dec.id_inst, dec.id_pc, halted);
      end
      dec.id_ready = 1'b1;
      step(); step(); step();
      checks++;
      if (dec.id_valid !== 1'b0 || pm_rd !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_fetch_after valid=%b rd=%b (want 0 0)", dec.id_valid, pm_rd);
      end
      dec.id_ready = 1'b0;
   endtask

   initial begin
      dec.id_ready = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = rand_word();
      test_reset();
      test_load_latency();
      test_wrap();
      test_backpressure();
      test_halt();
      test_redirect();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
